fp_normalizer: RTL and testbench

Multi-cycle post-arithmetic normalizer for the single-precision floating-point datapath. Operand alignment computes an exponent difference and right-shifts the smaller mantissa; this block does the opposite at the other end of the adder. It takes the raw sum exponent and mantissa, restores the hidden bit to its canonical position by right-shifting once on carry-out or left-shifting one bit per cycle, and adjusts the exponent to match. It sits between the mantissa adder and the rounding stage, and uses a valid/ready handshake on both sides.

---
 rtl/fp_normalizer.sv | 89 ++++++++
 tb/tb_fp_normalizer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-adder normalizer: restores the hidden bit with one right shift on carry-out
// or iterative single-bit left shifts, adjusting the exponent to match.
module fp_normalizer #(
    parameter int MANT_W = 26,
    parameter int CNT_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              zero,
    output logic              overflow,
    output logic              denorm
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t state;

    logic [8:0] exp_inc;
    assign exp_inc   = {1'b0, exp_out} + 9'd1;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // The output registers double as the working registers; they only move in NORM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            exp_out   <= '0;
            mant_out  <= '0;
            shift_cnt <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            denorm    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    exp_out   <= exp_in;
                    mant_out  <= mant_in;
                    shift_cnt <= '0;
                    zero      <= 1'b0;
                    overflow  <= 1'b0;
                    denorm    <= 1'b0;
                    state     <= NORM;
                end
                NORM: begin
                    if (mant_out == '0) begin
                        exp_out <= '0;
                        zero    <= 1'b1;
                        state   <= DONE;
                    end else if (mant_out[MANT_W-1]) begin
                        if (exp_inc >= 9'd255) begin
                            exp_out  <= 8'hFF;
                            mant_out <= '0;
                            overflow <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // Fold the two bits leaving the bottom into sticky.
                            exp_out  <= exp_inc[7:0];
                            mant_out <= {1'b0, mant_out[MANT_W-1:2], mant_out[1] | mant_out[0]};
                        end
                    end else if (mant_out[MANT_W-2]) begin
                        state <= DONE;
                    end else if (exp_out <= 8'd1) begin
                        exp_out <= '0;
                        denorm  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        mant_out  <= mant_out << 1;
                        exp_out   <= exp_out - 8'd1;
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed vectors push expected results,
// a monitor pops and compares on each output handshake.
module tb_fp_normalizer;
    localparam int MANT_W = 26;
    localparam int CNT_W  = 5;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        exp_in = '0;
    logic [MANT_W-1:0] mant_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        exp_out;
    logic [MANT_W-1:0] mant_out;
    logic [CNT_W-1:0]  shift_cnt;
    logic              zero, overflow, denorm;

    fp_normalizer #(.MANT_W(MANT_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_in(exp_in), .mant_in(mant_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .mant_out(mant_out), .shift_cnt(shift_cnt),
        .zero(zero), .overflow(overflow), .denorm(denorm)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]        e;
        logic [MANT_W-1:0] m;
        logic [CNT_W-1:0]  c;
        logic [2:0]        f;    // {zero, overflow, denorm}
        int                lat;
        int                acc;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drives one input; returns the index of the accepting edge.
    task automatic drive(input logic [7:0] e, input logic [MANT_W-1:0] m, output int acc);
        int i;
        for (i = 0; i < 200 && !in_ready; i++) @(negedge CLK);
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        exp_in   = e;
        mant_in  = m;
        acc      = cyc + 1;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] e, input logic [MANT_W-1:0] m,
                        input logic [7:0] ee, input logic [MANT_W-1:0] me,
                        input logic [CNT_W-1:0] ce, input logic [2:0] fe, input int lat);
        exp_t x;
        int   acc;
        @(negedge CLK);
        while (!in_ready) @(negedge CLK);
        x.e = ee; x.m = me; x.c = ce; x.f = fe; x.lat = lat; x.acc = cyc + 1;
        sb.push_back(x);
        drive(e, m, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge CLK);
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge CLK);
    endtask

    // Monitor: measures latency from the accept edge and compares on handshake.
    initial begin
        bit seen = 0;
        int rise = 0;
        exp_t x;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    rise = cyc;
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        x = sb.pop_front();
                        chk("exp_out",   32'(exp_out),   32'(x.e));
                        chk("mant_out",  32'(mant_out),  32'(x.m));
                        chk("shift_cnt", 32'(shift_cnt), 32'(x.c));
                        chk("flags",     32'({zero, overflow, denorm}), 32'(x.f));
                        chk("latency",   32'(rise - x.acc + 1), 32'(x.lat));
                    end
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin
        int acc;
        bit bad;

        repeat (2) @(negedge CLK);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs",   32'({exp_out, shift_cnt, zero, overflow, denorm}), 32'd0);
        chk("rst_mant",      32'(mant_out), 32'd0);
        nRST = 1'b1;

        //    exp_in  mant_in        exp    mant           cnt  {z,o,d} lat
        send(8'h80, 26'h0100000, 8'h7C, 26'h1000000, 5'd4,  3'b000, 6);
        send(8'h10, 26'h2000001, 8'h11, 26'h1000001, 5'd0,  3'b000, 3);
        send(8'hFE, 26'h2000000, 8'hFF, 26'h0000000, 5'd0,  3'b010, 2);
        send(8'h03, 26'h0000100, 8'h00, 26'h0000400, 5'd2,  3'b001, 4);
        send(8'h55, 26'h0000000, 8'h00, 26'h0000000, 5'd0,  3'b100, 2);
        send(8'h00, 26'h0100000, 8'h00, 26'h0100000, 5'd0,  3'b001, 2);
        send(8'h40, 26'h1234567, 8'h40, 26'h1234567, 5'd0,  3'b000, 2);
        send(8'h10, 26'h3FFFFFF, 8'h11, 26'h1FFFFFF, 5'd0,  3'b000, 3);
        send(8'h80, 26'h0000001, 8'h68, 26'h1000000, 5'd24, 3'b000, 26);
        send(8'h05, 26'h0000001, 8'h00, 26'h0000010, 5'd4,  3'b001, 6);
        send(8'h01, 26'h0800000, 8'h00, 26'h0800000, 5'd0,  3'b001, 2);
        drain();

        // Backpressure: result must hold while out_ready is low.
        @(posedge CLK); #1 out_ready = 1'b0;
        send(8'h40, 26'h1234567, 8'h40, 26'h1234567, 5'd0, 3'b000, 2);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_mant",      32'(mant_out),  32'h1234567);
            chk("stall_exp",       32'(exp_out),   32'h40);
        end
        @(posedge CLK); #1 out_ready = 1'b1;
        drain();

        // Flush mid-NORM: nothing is produced.
        drive(8'h80, 26'h0000001, acc);
        repeat (3) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (out_valid) bad = 1;
        end
        chk("flush_no_result", 32'(bad), 32'd0);

        // Asynchronous reset mid-NORM clears everything immediately.
        drive(8'h80, 26'h0000001, acc);
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_outputs",   32'({exp_out, shift_cnt, zero, overflow, denorm}), 32'd0);
        chk("arst_mant",      32'(mant_out),  32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Block must restart cleanly after the aborted operation.
        send(8'h80, 26'h0100000, 8'h7C, 26'h1000000, 5'd4, 3'b000, 6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d pending, expected 0", sb.size());
        $fatal(1, "timeout");
    end
endmodule
